// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM state encoding, default reset PC and word increment.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FULL  = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] WORD_INC     = 32'd4;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry IF/ID output register: instruction word, its address and a valid flag.
module fetch_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    // Flush wins over consume so a redirected word is dropped, never delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= load_instr;
            instr_pc    <= load_pc;
        end else if (consume) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time, handles redirects.
// Optional feature macro FETCH_FAULT_EN: bad redirect targets park the FSM in HALT with a sticky fault.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        fault
);

    localparam logic [32:0] IM_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    fetch_state_t state, state_n;
    logic [31:0]  pc_n, tgt, tgt_n, redir_tgt;
    logic         kill, kill_n;
    logic         load, flush, consume;

    function automatic logic bad_target(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < RESET_PC) || ({1'b0, addr} >= IM_END);
    endfunction

`ifdef FETCH_FAULT_EN
    assign redir_tgt = redirect_pc;
`else
    logic unused_redir_bits;
    assign unused_redir_bits = ^redirect_pc[1:0];
    assign redir_tgt = {redirect_pc[31:2], 2'b00};
`endif

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign consume   = instr_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            tgt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            kill  <= kill_n;
            tgt   <= tgt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        tgt_n   = tgt;
        load    = 1'b0;
        flush   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
                if (redirect_valid) begin
                    pc_n = redir_tgt;
`ifdef FETCH_FAULT_EN
                    if (bad_target(redir_tgt)) state_n = ST_HALT;
`endif
                end
            end
            ST_FETCH: begin
                // The request stays up until ack; redirects without ack are deferred via kill/tgt.
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_n   = redir_tgt;
                        kill_n = 1'b0;
`ifdef FETCH_FAULT_EN
                        if (bad_target(redir_tgt)) state_n = ST_HALT;
`endif
                    end else if (kill) begin
                        pc_n   = tgt;
                        kill_n = 1'b0;
`ifdef FETCH_FAULT_EN
                        if (bad_target(tgt)) state_n = ST_HALT;
`endif
                    end else begin
                        load    = 1'b1;
                        pc_n    = pc + WORD_INC;
                        state_n = ST_FULL;
                    end
                end else if (redirect_valid) begin
                    kill_n = 1'b1;
                    tgt_n  = redir_tgt;
                end
            end
            ST_FULL: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_n    = redir_tgt;
                    state_n = ST_FETCH;
`ifdef FETCH_FAULT_EN
                    if (bad_target(redir_tgt)) state_n = ST_HALT;
`endif
                end else if (consume) begin
                    state_n = ST_FETCH;
                end
            end
`ifdef FETCH_FAULT_EN
            ST_HALT: begin
                flush = 1'b1;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

`ifdef FETCH_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset) fault <= 1'b0;
        else       fault <= (state_n == ST_HALT);
    end
`else
    assign fault = 1'b0;
`endif

    fetch_out_reg u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .consume    (consume),
        .flush      (flush),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change and outputs are checked on the falling edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, instr_valid, fault;
    logic [31:0] imem_addr, instr, instr_pc, pc;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc,                  32'h3000);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,           32'h3000);
        chk({tag, "_vld"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr,               32'd0);
        chk({tag, "_ipc"},   instr_pc,            32'd0);
        chk({tag, "_fault"}, {31'd0, fault},       32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        tick();
        chk_reset_vals("rst");

        // Basic fetch with zero-wait memory
        reset = 1'b0;
        tick();
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h3000);
        imem_ack = 1'b1; imem_rdata = 32'h3c01_0001;
        tick();
        chk("t1_vld", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h3c01_0001);
        chk("t1_ipc", instr_pc, 32'h3000);
        chk("t1_req_full", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        tick();
        chk("t1_vld_consumed", {31'd0, instr_valid}, 32'd0);
        chk("t1_next_req", {31'd0, imem_req}, 32'd1);
        chk("t1_next_addr", imem_addr, 32'h3004);

        // Slow memory, then a 4-cycle stall
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_req", {31'd0, imem_req}, 32'd1);
            chk("t2_wait_addr", imem_addr, 32'h3004);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'haaaa_0001; stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_vld", {31'd0, instr_valid}, 32'd1);
            chk("t2_stall_instr", instr, 32'haaaa_0001);
            chk("t2_stall_ipc", instr_pc, 32'h3004);
            chk("t2_stall_req", {31'd0, imem_req}, 32'd0);
            if (i < 3) tick();
        end
        stall = 1'b0;
        tick();
        chk("t2_req_after", {31'd0, imem_req}, 32'd1);
        chk("t2_addr_after", imem_addr, 32'h3008);
        chk("t2_vld_after", {31'd0, instr_valid}, 32'd0);

        // Redirect in FULL while stalled drops the buffered word
        imem_ack = 1'b1; imem_rdata = 32'hbbbb_0002; stall = 1'b1;
        tick();
        chk("t3_vld", {31'd0, instr_valid}, 32'd1);
        chk("t3_ipc", instr_pc, 32'h3008);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("t3_vld_drop", {31'd0, instr_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h3100);

        // Two redirects during an outstanding request; latest target wins
        redirect_valid = 1'b1; redirect_pc = 32'h3200;
        tick();
        chk("t4_addr_hold1", imem_addr, 32'h3100);
        chk("t4_req_hold1", {31'd0, imem_req}, 32'd1);
        redirect_pc = 32'h3300;
        tick();
        chk("t4_addr_hold2", imem_addr, 32'h3100);
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
        tick();
        imem_ack = 1'b0;
        chk("t4_vld_drop", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h3300);
        chk("t4_req", {31'd0, imem_req}, 32'd1);

        // Redirect coinciding with ack
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        redirect_valid = 1'b1; redirect_pc = 32'h3400;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("t4b_vld_drop", {31'd0, instr_valid}, 32'd0);
        chk("t4b_addr", imem_addr, 32'h3400);

        // Reset with a request outstanding and kill pending
        redirect_valid = 1'b1; redirect_pc = 32'h3500;
        tick();
        redirect_valid = 1'b0; reset = 1'b1;
        tick();
        chk_reset_vals("t5_rst");
        reset = 1'b0;
        tick();
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr, 32'h3000);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        chk("t5_vld", {31'd0, instr_valid}, 32'd1);
        chk("t5_instr", instr, 32'h1111_2222);
        chk("t5_ipc", instr_pc, 32'h3000);

        // Redirect in FULL overrides a same-cycle consume
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
        tick();
        imem_ack = 1'b0;
        chk("t5b_ipc", instr_pc, 32'h3004);
        redirect_valid = 1'b1; redirect_pc = 32'h3600;
        tick();
        redirect_valid = 1'b0;
        chk("t5b_vld_drop", {31'd0, instr_valid}, 32'd0);
        chk("t5b_addr", imem_addr, 32'h3600);

        // Misaligned redirect target with ack
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        redirect_valid = 1'b1; redirect_pc = 32'h3002;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
`ifdef FETCH_FAULT_EN
        for (int i = 0; i < 3; i++) begin
            chk("t6_fault", {31'd0, fault}, 32'd1);
            chk("t6_req", {31'd0, imem_req}, 32'd0);
            chk("t6_pc", pc, 32'h3002);
            chk("t6_vld", {31'd0, instr_valid}, 32'd0);
            tick();
        end
`else
        chk("t6_fault", {31'd0, fault}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'h3000);
        chk("t6_vld", {31'd0, instr_valid}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
